// File: rtl/multi_freq_divider.sv
// Multi-channel programmable clock divider with glitch-free shadowed divisor reload.
// Optional macro DIVIDER_PHASE_ALIGN_EN adds a 'sync' input that phase-aligns every channel.
module multi_freq_divider #(
    parameter int               CHANNELS    = 4,
    parameter int               CNT_W       = 32,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(25)
) (
    input  logic                                            CLKin,
    input  logic                                            clr,
`ifdef DIVIDER_PHASE_ALIGN_EN
    input  logic                                            sync,
`endif
    input  logic [CHANNELS-1:0]                             en,
    input  logic                                            wr_en,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_ch,
    input  logic [CNT_W-1:0]                                wr_div,
    output logic [CHANNELS-1:0]                             CLKout,
    output logic [CHANNELS-1:0]                             tick,
    output logic [CHANNELS-1:0]                             pend
);

    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];
    logic [CNT_W-1:0]    div_q [CHANNELS];
    logic [CNT_W-1:0]    div_d [CHANNELS];
    logic [CNT_W-1:0]    shd_q [CHANNELS];
    logic [CNT_W-1:0]    shd_d [CHANNELS];
    logic [CHANNELS-1:0] pend_q, pend_d;
    logic [CHANNELS-1:0] clk_q, clk_d;
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [CHANNELS-1:0] wrHit, wrap;

    // Out-of-range channel numbers never match any index, so such writes vanish.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            wrHit[i] = wr_en && (32'(wr_ch) == 32'(i));
            wrap[i]  = en[i] && (cnt_q[i] == div_q[i]);
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        clk_d  = clk_q;
        tick_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
`ifdef DIVIDER_PHASE_ALIGN_EN
            if (sync) begin
                if (pend_q[i]) begin
                    div_d[i] = shd_q[i];
                end
                pend_d[i] = 1'b0;
                cnt_d[i]  = '0;
                clk_d[i]  = 1'b0;
                if (wrHit[i]) begin
                    shd_d[i]  = wr_div;
                    pend_d[i] = 1'b1;
                end
            end else
`endif
            if (wrap[i]) begin
                cnt_d[i]  = '0;
                clk_d[i]  = ~clk_q[i];
                tick_d[i] = ~clk_q[i];
                // A write landing on the wrap bypasses the shadow entirely.
                if (wrHit[i]) begin
                    div_d[i]  = wr_div;
                    shd_d[i]  = wr_div;
                    pend_d[i] = 1'b0;
                end else if (pend_q[i]) begin
                    div_d[i]  = shd_q[i];
                    pend_d[i] = 1'b0;
                end
            end else if (!en[i] && pend_q[i]) begin
                div_d[i]  = shd_q[i];
                pend_d[i] = 1'b0;
                cnt_d[i]  = '0;
                clk_d[i]  = 1'b0;
                if (wrHit[i]) begin
                    shd_d[i]  = wr_div;
                    pend_d[i] = 1'b1;
                end
            end else begin
                if (en[i]) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
                if (wrHit[i]) begin
                    shd_d[i]  = wr_div;
                    pend_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLKin) begin
        if (clr) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= DEFAULT_DIV;
                shd_q[i] <= DEFAULT_DIV;
            end
            pend_q <= '0;
            clk_q  <= '0;
            tick_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign CLKout = clk_q;
    assign tick   = tick_q;
    assign pend   = pend_q;

endmodule
